// File: rtl/ddfs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddfs_pkg
// Brief    : Shared types and limits for the DDFS oscillator cores and the
//            wavetable read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ddfs_pkg;

    localparam int SAMPLE_DW  = 16;
    localparam int RD_LAT_MAX = 4;

    typedef logic [1:0][SAMPLE_DW-1:0] sample_pair_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Rotating-priority arbiter. Search starts at the pointer and the
//            pointer moves one past each winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_mask,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);

    localparam int c_idx_w = $clog2(N);

    logic [c_idx_w-1:0] r_ptr;
    logic [c_idx_w-1:0] w_win_idx;
    logic [N-1:0]       w_elig;

    always_comb begin
        w_elig    = i_req & ~i_mask;
        o_grant   = '0;
        o_valid   = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            int pos;
            pos = (int'(r_ptr) + i) % N;
            if (!o_valid && w_elig[pos]) begin
                o_valid      = 1'b1;
                o_grant[pos] = 1'b1;
                w_win_idx    = c_idx_w'(pos);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            r_ptr <= (w_win_idx == c_idx_w'(N - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wavetable_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_read_arbiter
// Brief    : Shares one wavetable memory port among NCH oscillator cores and
//            routes each fixed-latency read result back to its requester.
// Revision : 1.0 - initial release
// ============================================================================
module wavetable_read_arbiter
    import ddfs_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int AW     = 12,
    parameter int DW     = SAMPLE_DW,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0][AW-1:0]  req_addr,
    output logic [NCH-1:0]          gnt,
    output logic [AW-1:0]           mem_addr,
    output logic                    mem_rd,
    input  logic [1:0][DW-1:0]      mem_interp,
    input  logic [1:0][DW-1:0]      mem_anti,
    output logic [NCH-1:0]          rsp_valid,
    output logic [1:0][DW-1:0]      rsp_interp,
    output logic [1:0][DW-1:0]      rsp_anti,
    output logic                    busy
);

    localparam int c_idx_w = $clog2(NCH);
    localparam int c_lat   = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [NCH-1:0]                  w_win;
    logic                            w_win_vld;
    logic [c_idx_w-1:0]              w_win_idx;

    logic [NCH-1:0]                  r_gnt;
    logic                            r_mem_rd;
    logic [AW-1:0]                   r_mem_addr;
    logic [c_idx_w-1:0]              r_idx;
    logic [c_lat-1:0]                r_pipe_vld;
    logic [c_lat-1:0][c_idx_w-1:0]   r_pipe_idx;

    // Masking with the current grant stops a still-high req from winning twice in a row.
    rr_arbiter #(.N(NCH)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req),
        .i_mask  (r_gnt),
        .o_grant (w_win),
        .o_valid (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_win[i]) w_win_idx = w_win_idx | c_idx_w'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_idx      <= '0;
        end else begin
            r_gnt    <= w_win;
            r_mem_rd <= w_win_vld;
            r_idx    <= w_win_idx;
            if (w_win_vld) r_mem_addr <= req_addr[w_win_idx];
        end
    end

    // Stage j holds the read issued j+1 cycles ago; the last stage lines up with memory data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            r_pipe_idx <= '0;
        end else begin
            r_pipe_vld[0] <= r_mem_rd;
            r_pipe_idx[0] <= r_idx;
            for (int j = 1; j < c_lat; j++) begin
                r_pipe_vld[j] <= r_pipe_vld[j-1];
                r_pipe_idx[j] <= r_pipe_idx[j-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_pipe_vld[c_lat-1]) rsp_valid[r_pipe_idx[c_lat-1]] = 1'b1;
    end

    assign gnt        = r_gnt;
    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign rsp_interp = mem_interp;
    assign rsp_anti   = mem_anti;
    assign busy       = (|r_pipe_vld) | r_mem_rd;

endmodule
`default_nettype wire
